// File: rtl/fetch_buffer_pkg.sv
// Shared Y86 fetch constants: icode encodings and the instruction length table
// used by the prefetch buffer and the fetch stage.
package fetch_buffer_pkg;

  localparam int INST_BYTES = 6;
  localparam int INST_W     = 8 * INST_BYTES;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  // Unknown icodes report length 1 so decode sees and flags them.
  function automatic logic [2:0] instLen(input logic [3:0] icode);
    logic [2:0] len;
    len = 3'd1;
    case (icode)
      I_HALT, I_NOP, I_RET:             len = 3'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 3'd2;
      I_JXX, I_CALL:                    len = 3'd5;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 3'd6;
      default:                          len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle of the redirect, ROM fetch and instruction delivery signals of fetch_buffer.
interface fetch_buffer_if #(
  parameter int FETCH_BYTES = 4
);
  // Handshakes: a ROM request transfers on a cycle with rom_req_o && rom_gnt_i;
  // rom_valid_i marks one in-order response word per cycle (no back-pressure);
  // an instruction transfers on a cycle with inst_valid_o && inst_ready_i.
  logic                       redirect_i;
  logic [31:0]                redirect_pc_i;
  logic                       rom_req_o;
  logic [31:0]                rom_addr_o;
  logic                       rom_gnt_i;
  logic                       rom_valid_i;
  logic [8*FETCH_BYTES-1:0]   rom_data_i;
  logic                       inst_valid_o;
  logic [47:0]                inst_o;
  logic [2:0]                 inst_len_o;
  logic [31:0]                pc_o;
  logic                       inst_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, rom_gnt_i, rom_valid_i, rom_data_i, inst_ready_i,
    output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_len_o, pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, rom_gnt_i, rom_valid_i, rom_data_i, inst_ready_i,
    input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_len_o, pc_o
  );
endinterface

// File: rtl/fetch_buffer_byte_queue.sv
// Circular byte storage: one word-wide write port that can drop leading bytes,
// and a 6-byte read window starting at the read pointer.
module fetch_byte_queue #(
  parameter int FETCH_BYTES = 4,
  parameter int QUEUE_BYTES = 16,
  localparam int QW = $clog2(QUEUE_BYTES),
  localparam int FW = $clog2(FETCH_BYTES)
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [QW-1:0]            wrPtr,
  input  logic [FW-1:0]            skip,
  input  logic [8*FETCH_BYTES-1:0] wrData,
  input  logic [QW-1:0]            rdPtr,
  output logic [47:0]              window
);

  logic [7:0] mem [QUEUE_BYTES];

  // Byte i of the word (MSB first) lands at wrPtr + i - skip; bytes below skip are dropped.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        if (i >= int'(skip)) begin
          mem[wrPtr + QW'(i) - QW'(skip)] <= wrData[8*(FETCH_BYTES-1-i) +: 8];
        end
      end
    end
  end

  always_comb begin
    window = '0;
    for (int k = 0; k < 6; k++) begin
      window[47-8*k -: 8] = mem[rdPtr + QW'(k)];
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch front-end: issues word fetches with a credit limit,
// queues returned bytes and presents one length-decoded instruction per cycle.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          FETCH_BYTES = 4,
  parameter int          QUEUE_BYTES = 16,
  parameter int          MAX_OUT     = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.master bus
);

  localparam int QW = $clog2(QUEUE_BYTES);
  localparam int CW = QW + 1;
  localparam int FW = $clog2(FETCH_BYTES);
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(FETCH_BYTES) - 32'd1);

  logic [QW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic [31:0]   fetchAddr, pc;
  logic [IW-1:0] inflight, stale;
  logic [FW-1:0] skip;

  logic [47:0]   window;
  logic [2:0]    headLen;
  logic          instValid, romReq, issue, fresh, pop;
  logic [CW-1:0] pushCnt, popCnt;
  logic [31:0]   room;

  fetch_byte_queue #(
    .FETCH_BYTES(FETCH_BYTES),
    .QUEUE_BYTES(QUEUE_BYTES)
  ) u_queue (
    .clk   (clk),
    .wrEn  (fresh && !bus.redirect_i),
    .wrPtr (wrPtr),
    .skip  (skip),
    .wrData(bus.rom_data_i),
    .rdPtr (rdPtr),
    .window(window)
  );

  // Requests reserve queue space for every word still in flight, so a push never overflows.
  always_comb begin
    headLen   = (count == '0) ? 3'd1 : instLen(window[47:44]);
    instValid = (count != '0) && (count >= CW'(headLen));
    room      = 32'(count) + 32'(FETCH_BYTES) * (32'(inflight) + 32'd1);
    romReq    = rst && !bus.redirect_i && (32'(inflight) < 32'(MAX_OUT)) &&
                (room <= 32'(QUEUE_BYTES));
    issue     = romReq && bus.rom_gnt_i;
    fresh     = bus.rom_valid_i && (stale == '0);
    pushCnt   = fresh ? (CW'(FETCH_BYTES) - CW'(skip)) : '0;
    pop       = instValid && bus.inst_ready_i;
    popCnt    = pop ? CW'(headLen) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      pc        <= RESET_PC;
      fetchAddr <= RESET_PC & ALIGN_MASK;
      skip      <= RESET_PC[FW-1:0];
      inflight  <= '0;
      stale     <= '0;
    end else if (bus.redirect_i) begin
      // Everything still outstanding belongs to the old stream; a response landing now is dropped too.
      count     <= '0;
      rdPtr     <= wrPtr;
      pc        <= bus.redirect_pc_i;
      fetchAddr <= bus.redirect_pc_i & ALIGN_MASK;
      skip      <= bus.redirect_pc_i[FW-1:0];
      inflight  <= inflight - IW'(bus.rom_valid_i);
      stale     <= inflight - IW'(bus.rom_valid_i);
    end else begin
      inflight <= inflight + IW'(issue) - IW'(bus.rom_valid_i);
      if (issue) fetchAddr <= fetchAddr + 32'(FETCH_BYTES);
      if (bus.rom_valid_i && (stale != '0)) stale <= stale - IW'(1);
      if (fresh) begin
        wrPtr <= wrPtr + QW'(pushCnt);
        skip  <= '0;
      end
      if (pop) begin
        rdPtr <= rdPtr + QW'(headLen);
        pc    <= pc + 32'(headLen);
      end
      count <= count + pushCnt - popCnt;
    end
  end

  assign bus.rom_req_o    = romReq;
  assign bus.rom_addr_o   = fetchAddr;
  assign bus.inst_valid_o = instValid;
  assign bus.inst_o       = window;
  assign bus.inst_len_o   = headLen;
  assign bus.pc_o         = pc;

endmodule
